seq_win_scanner: RTL

- Sequential five-in-a-row detector.
- Sits downstream of the move sources (keyboard player and AI). After each committed stone, it scans the 15x15 occupancy vector of the mover's colour around the placed cell and reports win or no-win.
- Replaces the wide combinational checker with a single-cell-per-cycle walker, so the design closes timing at full clk.

---
 rtl/gobang_pkg.sv | 41 ++++
 rtl/gobang_step.sv | 34 +++
 rtl/seq_win_scanner.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/gobang_pkg.sv
// Shared board geometry, FSM states and direction table for the gobang win scanner.
package gobang_pkg;

   localparam int unsigned BOARD_N = 15;
   localparam int unsigned CELLS   = BOARD_N * BOARD_N;
   localparam int unsigned WIN_LEN = 5;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StPos,
      StNeg,
      StDone
   } state_e;

   // d0=(0,+1) d1=(+1,0) d2=(+1,+1) d3=(+1,-1), as (dr,dc)
   function automatic logic signed [1:0] dir_dr(input logic [1:0] d);
      logic signed [1:0] v;
      unique case (d)
         2'd0:    v = 2'sb00;
         default: v = 2'sb01;
      endcase
      return v;
   endfunction

   function automatic logic signed [1:0] dir_dc(input logic [1:0] d);
      logic signed [1:0] v;
      unique case (d)
         2'd0:    v = 2'sb01;
         2'd1:    v = 2'sb00;
         2'd2:    v = 2'sb01;
         default: v = 2'sb11;
      endcase
      return v;
   endfunction

   function automatic logic [7:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
      return 8'(r) * 8'(BOARD_N) + 8'(c);
   endfunction

endpackage

// File: rtl/gobang_step.sv
// Combinational neighbour step: next coordinate along a direction, with bounds flag.
module gobang_step
   import gobang_pkg::*;
(
   input  logic [3:0] r_i,
   input  logic [3:0] c_i,
   input  logic [1:0] dir_i,
   input  logic       neg_i,
   output logic [3:0] r_o,
   output logic [3:0] c_o,
   output logic       in_bounds_o
);

   logic signed [1:0] dr2, dc2;
   logic signed [4:0] dr, dc, nr, nc;

   always_comb begin
      dr2 = dir_dr(dir_i);
      dc2 = dir_dc(dir_i);
      dr  = {{3{dr2[1]}}, dr2};
      dc  = {{3{dc2[1]}}, dc2};
      if (neg_i) begin
         dr = -dr;
         dc = -dc;
      end
      // One extra bit so a step off the low edge shows up as negative, never wrapping
      nr = $signed({1'b0, r_i}) + dr;
      nc = $signed({1'b0, c_i}) + dc;
      in_bounds_o = (nr >= 5'sd0) && (nr < 5'sd15) && (nc >= 5'sd0) && (nc < 5'sd15);
      r_o = nr[3:0];
      c_o = nc[3:0];
   end

endmodule

// File: rtl/seq_win_scanner.sv
// Sequential five-in-a-row detector walking one cell per cycle around the placed stone.
// STRICT_FIVE_EN selects the exact-five rule (no early stop, overlines do not win).
module seq_win_scanner
   import gobang_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [3:0]       row_i,
   input  logic [3:0]       col_i,
   input  logic [CELLS-1:0] board_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             win_o,
   output logic [3:0]       max_run_o
);

   localparam logic [3:0] BoardN = 4'(BOARD_N);
   localparam logic [3:0] WinLen = 4'(WIN_LEN);

   state_e             state_q, state_d;
   logic [3:0]         row_q, row_d, col_q, col_d;
   logic [CELLS-1:0]   board_q, board_d;
   logic [3:0]         cur_r_q, cur_r_d, cur_c_q, cur_c_d;
   logic [1:0]         dir_q, dir_d;
   logic [3:0]         run_q, run_d;
   logic               win_q, win_d;
   logic [3:0]         max_q, max_d;

   logic [3:0]         step_r, step_c;
   logic               step_ok, hit, do_eval, eval_win;
   logic [3:0]         eval_run, run_inc;

   gobang_step u_step (
      .r_i         (cur_r_q),
      .c_i         (cur_c_q),
      .dir_i       (dir_q),
      .neg_i       (state_q == StNeg),
      .r_o         (step_r),
      .c_o         (step_c),
      .in_bounds_o (step_ok)
   );

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      board_d  = board_q;
      cur_r_d  = cur_r_q;
      cur_c_d  = cur_c_q;
      dir_d    = dir_q;
      run_d    = run_q;
      win_d    = win_q;
      max_d    = max_q;
      hit      = 1'b0;
      do_eval  = 1'b0;
      eval_run = run_q;
      eval_win = 1'b0;
      run_inc  = run_q + 4'd1;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               row_d   = row_i;
               col_d   = col_i;
               board_d = board_i;
               win_d   = 1'b0;
               max_d   = 4'd0;
               dir_d   = 2'd0;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (row_q >= BoardN || col_q >= BoardN) begin
               state_d = StDone;
            end else if (!board_q[cell_idx(row_q, col_q)]) begin
               state_d = StDone;
            end else begin
               run_d   = 4'd1;
               cur_r_d = row_q;
               cur_c_d = col_q;
               dir_d   = 2'd0;
               state_d = StPos;
            end
         end
         StPos, StNeg: begin
            hit = step_ok ? board_q[cell_idx(step_r, step_c)] : 1'b0;
            if (hit) begin
               run_d   = run_inc;
               cur_r_d = step_r;
               cur_c_d = step_c;
`ifndef STRICT_FIVE_EN
               if (run_inc >= WinLen) begin
                  do_eval  = 1'b1;
                  eval_run = run_inc;
               end
`endif
            end else if (state_q == StPos) begin
               cur_r_d = row_q;
               cur_c_d = col_q;
               state_d = StNeg;
            end else begin
               do_eval = 1'b1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (do_eval) begin
         if (eval_run > max_q) max_d = eval_run;
`ifdef STRICT_FIVE_EN
         eval_win = (eval_run == WinLen);
`else
         eval_win = (eval_run >= WinLen);
`endif
         if (eval_win) begin
            win_d   = 1'b1;
            state_d = StDone;
         end else if (dir_q == 2'd3) begin
            state_d = StDone;
         end else begin
            dir_d   = dir_q + 2'd1;
            run_d   = 4'd1;
            cur_r_d = row_q;
            cur_c_d = col_q;
            state_d = StPos;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         row_q   <= '0;
         col_q   <= '0;
         board_q <= '0;
         cur_r_q <= '0;
         cur_c_q <= '0;
         dir_q   <= '0;
         run_q   <= '0;
         win_q   <= 1'b0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         board_q <= board_d;
         cur_r_q <= cur_r_d;
         cur_c_q <= cur_c_d;
         dir_q   <= dir_d;
         run_q   <= run_d;
         win_q   <= win_d;
         max_q   <= max_d;
      end
   end

   assign busy_o    = (state_q != StIdle);
   assign done_o    = (state_q == StDone);
   assign win_o     = win_q;
   assign max_run_o = max_q;

endmodule
